pipe_hazard_ctrl: RTL and testbench

Interlock and branch-wait controller for the in-order pipeline (IF, ID, EX, MEM, WB; no forwarding). It sits beside the ID stage and watches the instruction currently being decoded. It keeps a per-register scoreboard of pending writebacks and holds IF/ID while a source register is still in flight. It also holds IF/ID from the issue of a `BEQ`/`JUMP` until EX reports the branch resolved, injecting NOP bubbles into ID→EX during every hold.

---
 rtl/pipe_hazard_ctrl_if.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard controller.
//   master (ID stage side): drives instr_in, instr_valid, br_resolve;
//                           reads if_hold, id_bubble, issue, state, stall_cnt.
//   slave  (controller):    the opposite directions.
interface pipe_hazard_ctrl_if #(
  parameter int STAT_W = 16
);
  logic [31:0]       instr_in;
  logic              instr_valid;
  logic              br_resolve;
  logic              if_hold;
  logic              id_bubble;
  logic              issue;
  logic [1:0]        state;
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output instr_in, instr_valid, br_resolve,
    input  if_hold, id_bubble, issue, state, stall_cnt
  );

  modport slave (
    input  instr_in, instr_valid, br_resolve,
    output if_hold, id_bubble, issue, state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and branch-wait controller beside the ID stage of an in-order
// IF/ID/EX/MEM/WB pipeline without forwarding.
//   clk, rst_n   : pipeline clock, asynchronous active-low reset
//   bus (slave)  : instr_in/instr_valid/br_resolve in;
//                  if_hold/id_bubble/issue/state/stall_cnt out
// A per-register countdown scoreboard tracks writebacks still in flight;
// IF/ID is held while a source is pending, and from a BEQ/JUMP issue until
// EX pulses br_resolve. Every held cycle injects a bubble into ID->EX.
// WB_LAT must fit in CNT_W bits (WB_LAT <= 2**CNT_W - 1).
module pipe_hazard_ctrl #(
  parameter int         WB_LAT  = 3,
  parameter int         CNT_W   = 2,
  parameter int         STAT_W  = 16,
  parameter logic [5:0] OP_LDW  = 6'h23,
  parameter logic [5:0] OP_SDW  = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_JUMP = 6'h02
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, BRW = 2'd2} state_e;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

  state_e            state_q, state_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  // decode
  logic [5:0] opc;
  logic [4:0] fa, fb, fc;
  logic [4:0] src1, src2, dest;
  logic       is_jump, is_br, src2_a, no_dest;

  assign opc     = bus.instr_in[31:26];
  assign fa      = bus.instr_in[25:21];
  assign fb      = bus.instr_in[20:16];
  assign fc      = bus.instr_in[15:11];
  assign is_jump = (opc == OP_JUMP);
  assign is_br   = (opc == OP_BEQ) | is_jump;
  assign src2_a  = (opc == OP_SDW) | (opc == OP_BEQ) | (opc == OP_LDW);
  assign no_dest = (opc == OP_SDW) | (opc == OP_BEQ) | is_jump;
  // JUMP reads nothing: steer both sources to r0, which is never pending
  assign src1    = is_jump ? 5'd0 : fb;
  assign src2    = is_jump ? 5'd0 : (src2_a ? fa : fc);
  assign dest    = no_dest ? 5'd0 : fa;

  // scoreboard: pend[r] set while r's writeback is not yet readable in ID
  logic [31:0] pend;
  logic        hazard, issue_w, hold_w;

  assign pend[0] = 1'b0;
  assign hazard  = bus.instr_valid & (pend[src1] | pend[src2]);
  // rst_n gating keeps the outputs at their idle values while reset is held
  assign issue_w = rst_n & bus.instr_valid & ~hazard & (state_q != BRW);
  assign hold_w  = rst_n & ((bus.instr_valid & hazard) | (state_q == BRW));

  for (genvar i = 1; i < 32; i++) begin : g_sb
    logic [CNT_W-1:0] c_q, c_d;
    logic             wr;

    assign wr      = issue_w & (dest == 5'(i));
    assign pend[i] = |c_q;

    // a fresh issue to this register reloads over the running decrement
    always_comb begin
      c_d = c_q;
      if (wr)          c_d = LAT;
      else if (|c_q)   c_d = c_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c_q <= '0;
      else        c_q <= c_d;
    end
  end

  // FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, HAZ: begin
        if (issue_w & is_br) state_d = BRW;
        else if (hazard)     state_d = HAZ;
        else                 state_d = RUN;
      end
      BRW:     if (bus.br_resolve) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // stall statistics, saturating
  always_comb begin
    stall_d = stall_q;
    if (hold_w && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign bus.issue     = issue_w;
  assign bus.if_hold   = hold_w;
  assign bus.id_bubble = ~issue_w;
  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed bench for pipe_hazard_ctrl. Two instances share the
// same stimulus: the default one (STAT_W=16) and a STAT_W=4 one for the
// saturation case. The reference model tracks, per register, the cycle at
// which its value becomes readable, and the branch-wait/hazard mode.
module tb_pipe_hazard_ctrl;
  localparam int         WB_LAT  = 3;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_SDW  = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_OTH  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        brr = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAT_W(16)) bus16 ();
  pipe_hazard_ctrl_if #(.STAT_W(4))  bus4 ();

  assign bus16.instr_in = instr;  assign bus4.instr_in = instr;
  assign bus16.instr_valid = valid; assign bus4.instr_valid = valid;
  assign bus16.br_resolve = brr;  assign bus4.br_resolve = brr;

  pipe_hazard_ctrl #(.STAT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  pipe_hazard_ctrl #(.STAT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int unsigned cyc_n = 0;
  int unsigned rdy[32];   // first cycle at which register r is readable in ID
  int          mst = 0;   // 0 RUN, 1 HAZ, 2 BRW
  int          mstall = 0, mstall4 = 0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
    return {op, a, b, c, 11'h000};
  endfunction

  function automatic void decode(input logic [31:0] ins, output logic [4:0] s1,
                                 output logic [4:0] s2, output logic [4:0] d,
                                 output bit isbr);
    logic [5:0] op;
    op = ins[31:26];
    s1 = ins[20:16];
    s2 = ins[15:11];
    d  = ins[25:21];
    isbr = (op == OP_BEQ) || (op == OP_JUMP);
    if (op == OP_JUMP) begin s1 = 0; s2 = 0; d = 0; end
    else if (op == OP_SDW || op == OP_BEQ) begin s2 = ins[25:21]; d = 0; end
    else if (op == OP_LDW) s2 = ins[25:21];
  endfunction

  // One pipeline cycle: apply inputs, check at negedge, advance the model.
  task automatic cyc(input logic [31:0] ins, input logic v, input logic br);
    logic [4:0] s1, s2, d;
    bit isbr, hz, iss, hold;
    instr = ins; valid = v; brr = br;
    @(negedge clk);
    decode(ins, s1, s2, d, isbr);
    hz   = v && ((s1 != 0 && cyc_n < rdy[s1]) || (s2 != 0 && cyc_n < rdy[s2]));
    iss  = v && !hz && (mst != 2);
    hold = (v && hz) || (mst == 2);
    chk("issue",     bus16.issue,     iss);
    chk("if_hold",   bus16.if_hold,   hold);
    chk("id_bubble", bus16.id_bubble, !iss);
    chk("state",     bus16.state,     mst);
    chk("stall_cnt", bus16.stall_cnt, mstall);
    chk("issue4",    bus4.issue,      iss);
    chk("state4",    bus4.state,      mst);
    chk("stall4",    bus4.stall_cnt,  mstall4);
    if (hold) begin
      if (mstall < 65535) mstall++;
      if (mstall4 < 15)   mstall4++;
    end
    if (iss && d != 0) rdy[d] = cyc_n + 1 + WB_LAT;
    if (iss && isbr)   mst = 2;
    else if (mst == 2) mst = br ? 0 : 2;
    else               mst = (v && hz) ? 1 : 0;
    cyc_n++;
    @(posedge clk); #1;
  endtask

  // Async reset: outputs must reach idle values before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_issue",  bus16.issue,     0);
    chk("rst_hold",   bus16.if_hold,   0);
    chk("rst_bubble", bus16.id_bubble, 1);
    chk("rst_state",  bus16.state,     0);
    chk("rst_stall",  bus16.stall_cnt, 0);
    chk("rst_stall4", bus4.stall_cnt,  0);
    mst = 0; mstall = 0; mstall4 = 0;
    foreach (rdy[r]) rdy[r] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    int         k;
    foreach (rdy[r]) rdy[r] = 0;
    #1;
    valid = 1'b1; instr = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    do_reset();

    // dependency stall: reader of r5 right after writer
    cyc(mk(OP_ADD, 5'd5, 5'd1, 5'd2), 1, 0);
    for (int i = 0; i < 4; i++) cyc(mk(OP_ADD, 5'd6, 5'd5, 5'd3), 1, 0);
    chk("dep_stall", bus16.stall_cnt, 3);

    // independent back-to-back
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(mk(OP_ADD, 5'(8 + i), 5'(20 + i), 5'd0), 1, 0);
    chk("indep_stall", bus16.stall_cnt, 0);
    chk("indep_state", bus16.state, 0);

    // r0 never pending; WAW reload restarts the window
    do_reset();
    cyc(mk(OP_ADD, 5'd0, 5'd1, 5'd2), 1, 0);
    cyc(mk(OP_ADD, 5'd9, 5'd0, 5'd0), 1, 0);
    chk("r0_stall", bus16.stall_cnt, 0);
    cyc(mk(OP_ADD, 5'd7, 5'd1, 5'd2), 1, 0);
    cyc(mk(OP_ADD, 5'd8, 5'd1, 5'd2), 1, 0);
    cyc(mk(OP_ADD, 5'd7, 5'd1, 5'd2), 1, 0);
    for (int i = 0; i < 4; i++) cyc(mk(OP_ADD, 5'd9, 5'd7, 5'd0), 1, 0);
    chk("waw_stall", bus16.stall_cnt, 3);

    // branch wait of 4 cycles, then stray resolve in RUN
    do_reset();
    cyc(mk(OP_BEQ, 5'd1, 5'd2, 5'd0), 1, 0);
    for (int i = 0; i < 3; i++) cyc(mk(OP_ADD, 5'd3, 5'd4, 5'd5), 1, 0);
    cyc(mk(OP_ADD, 5'd3, 5'd4, 5'd5), 1, 1);
    chk("br_stall", bus16.stall_cnt, 4);
    chk("br_run", bus16.state, 0);
    cyc(mk(OP_ADD, 5'd10, 5'd11, 5'd12), 1, 1);
    chk("stray_res", bus16.state, 0);
    // resolve coincident with issue is ignored
    cyc(mk(OP_JUMP, 5'd0, 5'd0, 5'd0), 1, 1);
    chk("jump_brw", bus16.state, 2);
    cyc(mk(OP_ADD, 5'd1, 5'd1, 5'd1), 1, 1);

    // reset while in BRW with r3 pending
    do_reset();
    cyc(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 1, 0);
    cyc(mk(OP_BEQ, 5'd1, 5'd2, 5'd0), 1, 0);
    chk("pre_rst_brw", bus16.state, 2);
    instr = mk(OP_ADD, 5'd4, 5'd3, 5'd0);
    do_reset();
    cyc(mk(OP_ADD, 5'd4, 5'd3, 5'd0), 1, 0);
    chk("post_rst_stall", bus16.stall_cnt, 0);

    // saturation of the 4-bit counter
    do_reset();
    cyc(mk(OP_BEQ, 5'd0, 5'd0, 5'd0), 1, 0);
    for (int i = 0; i < 20; i++) cyc(mk(OP_ADD, 5'd1, 5'd2, 5'd3), 1, 0);
    chk("sat4", bus4.stall_cnt, 15);
    chk("sat16", bus16.stall_cnt, 20);
    cyc(mk(OP_ADD, 5'd1, 5'd2, 5'd3), 1, 1);

    // random traffic over a small register window to force hazards
    do_reset();
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 19);
      op = (k < 8) ? OP_ADD : (k < 11) ? OP_LDW : (k < 14) ? OP_SDW :
           (k < 16) ? OP_OTH : (k < 18) ? OP_BEQ : OP_JUMP;
      cyc(mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7))),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
